// File: rtl/adder_pkg.sv
// Shared types and constants for the adder result checker.
package adder_pkg;

    localparam int CNT_W     = 16;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and
// a combinational head output.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/adder_checker.sv
// Scoreboard for an adder under test: queues a+b, compares results.
// Optional first-error capture: define ADDER_CHECKER_FIRST_ERR_EN.
module adder_checker
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     res_valid,
    input  logic [WIDTH:0]           sum,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err,
    output logic [1:0]               state
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    ,
    output logic [WIDTH:0]           first_exp,
    output logic [WIDTH:0]           first_act
`endif
);

    logic [WIDTH:0] exp_sum;
    logic [WIDTH:0] head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           hit;
    logic           miss;
    chk_state_e     state_q;
    chk_state_e     state_nx;

    assign exp_sum  = {1'b0, a} + {1'b0, b};
    assign op_ready = !full;
    assign push     = op_valid && op_ready;
    assign pop      = res_valid && !empty;
    assign hit      = pop && (head == sum);
    assign miss     = res_valid && (empty || (head != sum));
    assign state    = state_q;

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (exp_sum),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    always_comb begin
        state_nx = state_q;
        if (miss)
            state_nx = FAIL;
        else if (state_q == IDLE && (push || res_valid))
            state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            err          <= 1'b0;
            state_q      <= IDLE;
        end else begin
            if (hit && match_cnt != '1)
                match_cnt <= match_cnt + 1'b1;
            if (miss && mismatch_cnt != '1)
                mismatch_cnt <= mismatch_cnt + 1'b1;
            if (miss)
                err <= 1'b1;
            state_q <= state_nx;
        end
    end

`ifdef ADDER_CHECKER_FIRST_ERR_EN
    // An unexpected result has no expectation, so it records zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_exp <= '0;
            first_act <= '0;
        end else if (miss && !err) begin
            first_exp <= empty ? '0 : head;
            first_act <= sum;
        end
    end
`endif

endmodule
